// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decrypt core: byte S-boxes, GF(2^8) helpers,
// round constants, the key-schedule step and the controller state encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int unsigned NR = 10;

    // Index 0 and 11..15 are padding so a 4-bit counter can index directly.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplier m only ever takes the InvMixColumns constants 9, 11, 13, 14.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless bypassed for the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_bypass_mc,
    output logic [127:0] o_state
);

    logic [7:0] w_in  [16];
    logic [7:0] w_key [16];
    logic [7:0] w_ark [16];
    logic [7:0] w_mc  [16];

    always_comb begin
        w_in    = '{default: '0};
        w_key   = '{default: '0};
        w_ark   = '{default: '0};
        w_mc    = '{default: '0};
        o_state = '0;
        for (int i = 0; i < 16; i++) begin
            w_in[i]  = i_state[127-8*i -: 8];
            w_key[i] = i_rk[127-8*i -: 8];
        end
        // Row r of column c is fetched from column (c - r) mod 4 of the input.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[r+4*c] = inv_sbox(w_in[r + 4*((c - r) & 3)]) ^ w_key[r+4*c];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c+0] = gf_mul(w_ark[4*c], 4'd14) ^ gf_mul(w_ark[4*c+1], 4'd11)
                        ^ gf_mul(w_ark[4*c+2], 4'd13) ^ gf_mul(w_ark[4*c+3], 4'd9);
            w_mc[4*c+1] = gf_mul(w_ark[4*c], 4'd9) ^ gf_mul(w_ark[4*c+1], 4'd14)
                        ^ gf_mul(w_ark[4*c+2], 4'd11) ^ gf_mul(w_ark[4*c+3], 4'd13);
            w_mc[4*c+2] = gf_mul(w_ark[4*c], 4'd13) ^ gf_mul(w_ark[4*c+1], 4'd9)
                        ^ gf_mul(w_ark[4*c+2], 4'd14) ^ gf_mul(w_ark[4*c+3], 4'd11);
            w_mc[4*c+3] = gf_mul(w_ark[4*c], 4'd11) ^ gf_mul(w_ark[4*c+1], 4'd13)
                        ^ gf_mul(w_ark[4*c+2], 4'd9) ^ gf_mul(w_ark[4*c+3], 4'd14);
        end
        for (int i = 0; i < 16; i++) begin
            o_state[127-8*i -: 8] = i_bypass_mc ? w_ark[i] : w_mc[i];
        end
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decrypt core with a single-entry cached key schedule.
//   state | meaning
//   IDLE  | waiting for key/ciphertext, in_ready high
//   KEXP  | writing rk[1..10], one round key per cycle
//   INIT  | initial AddRoundKey with rk[10]
//   ROUND | inverse rounds 9..1
//   FINAL | last round without InvMixColumns, loads plaintext
//   DONE  | plaintext valid, waiting for out_ready
module aes128_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_blk;
    logic [127:0] r_pt;
    logic [127:0] r_rk [11];
    logic [3:0]   r_kcnt;
    logic [3:0]   r_rnd;
    logic         r_key_cached;

    logic         w_key_hit;
    logic         w_bypass_mc;
    logic [127:0] w_rk_next;
    logic [127:0] w_round_out;

    assign w_key_hit = r_key_cached && (key == r_rk[0]);
    assign w_rk_next = key_expand(r_rk[r_kcnt - 4'd1], RCON[r_kcnt]);
    assign plaintext = r_pt;

    // rnd reaches 0 on entry to FINAL, so the same select serves rk[0] there.
    aes_inv_round u_round (
        .i_state     (r_blk),
        .i_rk        (r_rk[r_rnd]),
        .i_bypass_mc (w_bypass_mc),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_bypass_mc = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_fsm_nxt = w_key_hit ? S_INIT : S_KEXP;
            end
            S_KEXP:  if (r_kcnt == 4'(NR)) w_fsm_nxt = S_INIT;
            S_INIT:  w_fsm_nxt = S_ROUND;
            S_ROUND: if (r_rnd == 4'd1) w_fsm_nxt = S_FINAL;
            S_FINAL: begin
                w_bypass_mc = 1'b1;
                w_fsm_nxt   = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk        <= '0;
            r_pt         <= '0;
            r_kcnt       <= '0;
            r_rnd        <= '0;
            r_key_cached <= 1'b0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_blk <= ciphertext;
                        if (!w_key_hit) begin
                            r_rk[0]      <= key;
                            r_key_cached <= 1'b0;
                            r_kcnt       <= 4'd1;
                        end
                    end
                end
                S_KEXP: begin
                    r_rk[r_kcnt] <= w_rk_next;
                    if (r_kcnt == 4'(NR)) r_key_cached <= 1'b1;
                    else                  r_kcnt       <= r_kcnt + 4'd1;
                end
                S_INIT: begin
                    r_blk <= r_blk ^ r_rk[NR];
                    r_rnd <= 4'(NR - 1);
                end
                S_ROUND: begin
                    r_blk <= w_round_out;
                    r_rnd <= r_rnd - 4'd1;
                end
                S_FINAL: r_pt <= w_round_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed and randomised checks of the iterative AES-128 decrypt core against FIPS-197
// vectors and an independently built encryption model.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] ciphertext = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] plaintext;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    aes128_decrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] bget(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] ref_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sb[w[3][23:16]] ^ rc, sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] rk, s, t;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = k;
        s  = p ^ k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = ref_expand(rk, rc);
            rc = gm(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[127-8*(row+4*c) -: 8] = sb[bget(s, row + 4*((c + row) % 4))];
            s = t;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = bget(s, 4*c);   a1 = bget(s, 4*c+1);
                    a2 = bget(s, 4*c+2); a3 = bget(s, 4*c+3);
                    t[127-8*(4*c)   -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                    t[127-8*(4*c+1) -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                    t[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                    t[127-8*(4*c+3) -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                end
                s = t;
            end
            s = s ^ rk;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [127:0] k, input logic [127:0] c);
        chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'd1);
        key        = k;
        ciphertext = c;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_out_valid_after_xfer"}, 128'(out_valid), 128'd0);
        chk({tag, "_in_ready_after_xfer"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_dir(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] p, input int lat);
        int cyc;
        send(tag, k, c);
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        chk({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
        wait_valid(cyc);
        chk({tag, "_latency"}, 128'(cyc), 128'(lat));
        chk({tag, "_pt"}, plaintext, p);
        drain(tag);
    endtask

    initial begin
        int           cyc;
        int           stall;
        logic [127:0] k, p, c;
        logic         m_cached;
        logic [127:0] m_key;
        logic         hit;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        step();
        step();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_pt", plaintext, 128'd0);
        rst_n = 1'b1;
        step();

        run_dir("c1_miss", K_C1, CT_C1, PT_C1, 21);
        run_dir("c1_hit", K_C1, CT_C1, PT_C1, 11);
        run_dir("b_miss", K_B, CT_B, PT_B, 21);

        // Backpressure in DONE while a different request is waved at the input.
        send("bp", K_B, CT_B);
        wait_valid(cyc);
        chk("bp_latency", 128'(cyc), 128'd11);
        for (int i = 0; i < 7; i++) begin
            key        = K_C1;
            ciphertext = CT_C1;
            in_valid   = 1'b1;
            step();
            chk("bp_pt_stable", plaintext, PT_B);
            chk("bp_in_ready_low", 128'(in_ready), 128'd0);
            chk("bp_out_valid_held", 128'(out_valid), 128'd1);
        end
        in_valid = 1'b0;
        drain("bp");
        step();
        chk("bp_no_ghost_txn", 128'(busy), 128'd0);

        // Abort mid-ROUND on a cache hit; the cache must be gone afterwards.
        send("abort", K_B, CT_B);
        for (int i = 0; i < 5; i++) step();
        chk("abort_busy_pre", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_pt", plaintext, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        run_dir("b_after_rst", K_B, CT_B, PT_B, 21);

        m_cached = 1'b1;
        m_key    = K_B;
        k        = K_B;
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 2) != 0) k = {$urandom, $urandom, $urandom, $urandom};
            p   = {$urandom, $urandom, $urandom, $urandom};
            c   = ref_encrypt(k, p);
            hit = m_cached && (k == m_key);
            send("rnd", k, c);
            m_cached = 1'b1;
            m_key    = k;
            wait_valid(cyc);
            chk("rnd_latency", 128'(cyc), hit ? 128'd11 : 128'd21);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                chk("rnd_pt_stall", plaintext, p);
                step();
            end
            chk("rnd_pt", plaintext, p);
            chk("rnd_valid", 128'(out_valid), 128'd1);
            drain("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
